// File: rtl/machine_pkg.sv
// Shared types and field helpers for the machine datapath width converters.
package machine_pkg;

    localparam int unsigned TAG_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = TAG_W + DATA_W;

    typedef enum logic [2:0] {
        S_EVEN,
        S_ODD,
        S_TAIL,
        S_PAD,
        S_CSUM
    } state_e;

    function automatic logic [TAG_W-1:0] word_tag(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] word_data(input logic [WORD_W-1:0] w);
        return w[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/machine_tx_packer_if.sv
// Word-in / byte-out stream bundle for machine_tx_packer; slave is the packer's view.
interface machine_tx_packer_if;
    import machine_pkg::*;

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/machine_tx_outreg.sv
// Registered output byte slot: holds data/last while stalled, exposes slot_free.
module machine_tx_outreg
    import machine_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              slot_free
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    assign slot_free = !valid_q | out_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            data_d  = load_data;
            last_d  = load_last;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: rtl/machine_tx_packer.sv
// Packs 12-bit {tag,data} words into a dense byte stream (2 words -> 3 bytes).
// Optional per-frame XOR checksum byte: define MACHINE_TX_PACKER_CHECKSUM_EN.
module machine_tx_packer
    import machine_pkg::*;
#(
    parameter logic [3:0] PAD_NIBBLE = 4'h0
)(
    input  logic               system1000,
    input  logic               system1000_rstn,
    machine_tx_packer_if.slave bus
);

    state_e            state_q, state_d;
    logic [3:0]        residue_q, residue_d;
    logic [DATA_W-1:0] residue8_q, residue8_d;
    logic              last_q, last_d;

    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              slot_free;
    logic              accept;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_dat;

    assign in_tag      = word_tag(bus.in_data);
    assign in_dat      = word_data(bus.in_data);
    assign bus.in_ready = slot_free & (state_q == S_EVEN || state_q == S_ODD);
    assign accept      = bus.in_valid & bus.in_ready;

`ifdef MACHINE_TX_PACKER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d, csum_now;
    logic              csum_out_q, csum_out_d;
    logic              xfer;

    // csum_now folds in the byte leaving this cycle so the checksum load sees it
    assign xfer     = bus.out_valid & bus.out_ready;
    assign csum_now = csum_q ^ (xfer ? bus.out_data : '0);

    always_comb begin
        csum_d     = (xfer && csum_out_q) ? '0 : csum_now;
        csum_out_d = load ? (state_q == S_CSUM) : csum_out_q;
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            csum_q     <= '0;
            csum_out_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_out_q <= csum_out_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        residue_d  = residue_q;
        residue8_d = residue8_q;
        last_d     = last_q;
        load       = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        case (state_q)
            S_EVEN: if (accept) begin
                load      = 1'b1;
                load_data = {in_tag, in_dat[7:4]};
                residue_d = in_dat[3:0];
                state_d   = bus.in_last ? S_PAD : S_ODD;
            end
            S_ODD: if (accept) begin
                load       = 1'b1;
                load_data  = {residue_q, in_tag};
                residue8_d = in_dat;
                last_d     = bus.in_last;
                state_d    = S_TAIL;
            end
            S_TAIL: if (slot_free) begin
                load      = 1'b1;
                load_data = residue8_q;
`ifdef MACHINE_TX_PACKER_CHECKSUM_EN
                state_d   = last_q ? S_CSUM : S_EVEN;
`else
                load_last = last_q;
                state_d   = S_EVEN;
`endif
            end
            S_PAD: if (slot_free) begin
                load      = 1'b1;
                load_data = {residue_q, PAD_NIBBLE};
`ifdef MACHINE_TX_PACKER_CHECKSUM_EN
                state_d   = S_CSUM;
`else
                load_last = 1'b1;
                state_d   = S_EVEN;
`endif
            end
`ifdef MACHINE_TX_PACKER_CHECKSUM_EN
            S_CSUM: if (slot_free) begin
                load      = 1'b1;
                load_data = csum_now;
                load_last = 1'b1;
                state_d   = S_EVEN;
            end
`endif
            default: state_d = S_EVEN;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q    <= S_EVEN;
            residue_q  <= '0;
            residue8_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residue_q  <= residue_d;
            residue8_q <= residue8_d;
            last_q     <= last_d;
        end
    end

    machine_tx_outreg u_outreg (
        .clk       (system1000),
        .rst_n     (system1000_rstn),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_machine_tx_packer.sv
// Directed + random bench for machine_tx_packer with a byte scoreboard.
module tb_machine_tx_packer;
    import machine_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    machine_tx_packer_if bus ();

    machine_tx_packer #(.PAD_NIBBLE(4'h0)) dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .bus             (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_q[$];
    int         xfer_cyc[$];

    // out_ready driver: 0 = forced level, 1 = fixed pattern, 2 = random
    int   rdy_mode = 0;
    logic rdy_force = 1'b1;
    int   pat_idx = 0;
    logic rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    bus.out_ready = (pat_idx < 6) ? rdy_pat[pat_idx] : 1'b1;
                    pat_idx++;
                end
                2: bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = rdy_force;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_data", {24'd0, bus.out_data}, {24'd0, prev_data});
                check("hold_last", {31'd0, bus.out_last}, {31'd0, prev_last});
            end
            if (bus.out_valid && !bus.out_ready)
                check("in_ready_blocked", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {23'd0, bus.out_last, bus.out_data}, 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    // Reference packing model
    logic [3:0] m_res = '0;
    bit         m_odd = 1'b0;
    logic [7:0] m_acc = '0;

    task automatic exp_byte(input logic [7:0] b, input logic l);
`ifdef MACHINE_TX_PACKER_CHECKSUM_EN
        m_acc ^= b;
        exp_q.push_back({1'b0, b});
        if (l) begin
            exp_q.push_back({1'b1, m_acc});
            m_acc = '0;
        end
`else
        exp_q.push_back({l, b});
`endif
    endtask

    task automatic model_word(input logic [11:0] w, input logic l);
        if (!m_odd) begin
            exp_byte(w[11:4], 1'b0);
            m_res = w[3:0];
            if (l) exp_byte({m_res, 4'h0}, 1'b1);
            else   m_odd = 1'b1;
        end else begin
            exp_byte({m_res, w[11:8]}, 1'b0);
            exp_byte(w[7:0], l);
            m_odd = 1'b0;
        end
    endtask

    task automatic send_word(input logic [11:0] w, input logic l);
        int waitc = 0;
        model_word(w, l);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && waitc < 500) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int waitc = 0;
        while (exp_q.size() != 0 && waitc < 2000) begin
            @(posedge clk);
            waitc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

`ifdef MACHINE_TX_PACKER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_state", {29'd0, dut.state_q}, {29'd0, S_EVEN});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pair ending cleanly on B, full rate
        xfer_cyc.delete();
        send_word(12'hABC, 1'b0);
        send_word(12'h123, 1'b1);
        drain();
        check("t1_nbytes", xfer_cyc.size(), 3 + CS);
        check("t1_gap01", xfer_cyc[1] - xfer_cyc[0], 32'd1);
        check("t1_gap12", xfer_cyc[2] - xfer_cyc[1], 32'd1);

        // Odd word forces a pad byte
        send_word(12'h5A7, 1'b1);
        drain();

        // Same pair under patterned backpressure
        pat_idx  = 0;
        rdy_mode = 1;
        send_word(12'hABC, 1'b0);
        send_word(12'h123, 1'b1);
        drain();
        rdy_mode = 0;

        // Reset with a byte pending and residue held
        rdy_force = 1'b0;
        @(posedge clk);
        #2;
        send_word(12'hABC, 1'b0);
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_data", {24'd0, bus.out_data}, 32'hAB);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_state", {29'd0, dut.state_q}, {29'd0, S_EVEN});
        exp_q.delete();
        m_odd = 1'b0;
        m_acc = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_force = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        send_word(12'hFFF, 1'b1);
        drain();

        // Random frames, random backpressure and input gaps
        rdy_mode = 2;
        for (int i = 0; i < 100; i++) begin
            logic [11:0] w;
            logic        l;
            w = 12'($urandom);
            l = (i == 99) || ($urandom_range(0, 3) == 0);
            send_word(w, l);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;

        // Steady-state rate: 20 words -> 30 bytes on consecutive cycles
        xfer_cyc.delete();
        for (int i = 0; i < 20; i++)
            send_word(12'(i * 37 + 5), i == 19);
        drain();
        check("rate_nbytes", xfer_cyc.size(), 30 + CS);
        check("rate_span", xfer_cyc[xfer_cyc.size() - 1] - xfer_cyc[0], 29 + CS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
